unpermute_intt: RTL and testbench

- Handshaked, registered lane de-interleaver on the INTT path.
- Undoes the forward-NTT even/odd lane interleave so butterfly outputs return to natural half-split order before the inverse butterflies and write-back.
- Sits between the BFU array output and the coefficient RAM write port.
- Holds two beats in a skid buffer and tags polynomial boundaries with a beat counter.

---
 rtl/unpermute_intt.sv | 176 +++++++++++++++++
 tb/tb_unpermute_intt.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpermute_intt.sv
// Handshaked, registered lane de-interleaver on the INTT path.
// Undoes the forward-NTT even/odd lane interleave so butterfly outputs return to
// natural half-split order. An output register plus one skid register decouple the
// handshake, and a beat counter tags the final beat of each polynomial.
// Optional feature: define UNPERMUTE_RANGE_CHECK_EN to add a sticky o_range_err flag
// for any accepted lane >= q (3329).
module unpermute_intt #(
    parameter int unsigned HALF_NUM_BFU   = 16,
    parameter int unsigned BEATS_PER_POLY = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_flush,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic                               i_intt,
    input  logic                               i_permute,
    input  logic [2*HALF_NUM_BFU-1:0][15:0]    i_a,
    input  logic [2*HALF_NUM_BFU-1:0][15:0]    i_b,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [2*HALF_NUM_BFU-1:0][15:0]    o_a,
    output logic [2*HALF_NUM_BFU-1:0][15:0]    o_b,
    output logic                               o_last
`ifdef UNPERMUTE_RANGE_CHECK_EN
    ,
    output logic                               o_range_err
`endif
);

    localparam int unsigned NumLanes = 2 * HALF_NUM_BFU;
    localparam int unsigned CntW     = (BEATS_PER_POLY > 1) ? $clog2(BEATS_PER_POLY) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BEATS_PER_POLY - 1);

    typedef logic [NumLanes-1:0][15:0] vec_t;

    vec_t            perm_a, perm_b;
    logic            in_fire, out_free, in_last;

    logic            out_valid_q, out_valid_d;
    vec_t            out_a_q, out_a_d, out_b_q, out_b_d;
    logic            out_last_q, out_last_d;
    logic            skid_valid_q, skid_valid_d;
    vec_t            skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic            skid_last_q, skid_last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;

    // Inverse interleave: even lanes of x/y form a, odd lanes form b.
    always_comb begin
        perm_a = i_a;
        perm_b = i_b;
        if (i_intt && i_permute) begin
            for (int i = 0; i < HALF_NUM_BFU; i++) begin
                perm_a[i]                = i_a[2*i];
                perm_b[i]                = i_a[2*i+1];
                perm_a[i+HALF_NUM_BFU]   = i_b[2*i];
                perm_b[i+HALF_NUM_BFU]   = i_b[2*i+1];
            end
        end
    end

    // Flush blocks acceptance in its own cycle; ready never depends on i_ready.
    assign o_ready  = ready_q & ~i_flush;
    assign in_fire  = i_valid & o_ready;
    assign out_free = ~out_valid_q | i_ready;
    assign in_last  = (cnt_q == LastCnt);

    // Next-state for the two-entry buffer and the beat counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        skid_last_d  = skid_last_q;
        cnt_d        = cnt_q;

        if (i_flush) begin
            cnt_d = '0;
        end else if (in_fire) begin
            cnt_d = in_last ? '0 : cnt_q + CntW'(1);
        end

        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // Skid is only ever full while o_ready is low, so it cannot
            // coincide with a new acceptance here.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_a_d      = skid_a_q;
                out_b_d      = skid_b_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_a_d     = perm_a;
                out_b_d     = perm_b;
                out_last_d  = in_last;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_a_d     = perm_a;
            skid_b_d     = perm_b;
            skid_last_d  = in_last;
        end

        ready_d = ~skid_valid_d;
    end

    // State registers; reset empties both entries and holds o_ready low until
    // the first clock after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_last_q  <= 1'b0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            skid_last_q  <= skid_last_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_a     = out_a_q;
    assign o_b     = out_b_q;
    assign o_last  = out_last_q;

`ifdef UNPERMUTE_RANGE_CHECK_EN
    logic range_hit;
    logic range_err_q;

    // Any raw input lane at or above q flags the beat.
    always_comb begin
        range_hit = 1'b0;
        for (int k = 0; k < NumLanes; k++) begin
            if (i_a[k] >= 16'd3329 || i_b[k] >= 16'd3329) begin
                range_hit = 1'b1;
            end
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            range_err_q <= 1'b0;
        end else if (in_fire && range_hit) begin
            range_err_q <= 1'b1;
        end
    end

    assign o_range_err = range_err_q;
`endif

endmodule

// File: tb/tb_unpermute_intt.sv
// Self-checking bench for unpermute_intt: table vectors, hand-written corner
// sequences and randomized traffic compared against a queue-based model.
module tb_unpermute_intt;

    localparam int H = 16;
    localparam int N = 2 * H;
    localparam int BPP = 4;

    typedef logic [N-1:0][15:0] vec_t;
    typedef struct {
        vec_t a;
        vec_t b;
        bit   last;
    } beat_t;
    typedef struct {
        bit          intt;
        bit          perm;
        int          lane;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic intt = 1'b0;
    logic permute = 1'b0;
    vec_t in_a = '0;
    vec_t in_b = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    vec_t out_a;
    vec_t out_b;
    logic out_last;
`ifdef UNPERMUTE_RANGE_CHECK_EN
    logic range_err;
`endif

    unpermute_intt #(
        .HALF_NUM_BFU  (H),
        .BEATS_PER_POLY(BPP)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_valid    (in_valid),
        .o_ready    (in_ready),
        .i_intt     (intt),
        .i_permute  (permute),
        .i_a        (in_a),
        .i_b        (in_b),
        .o_valid    (out_valid),
        .i_ready    (out_ready),
        .o_a        (out_a),
        .o_b        (out_b),
        .o_last     (out_last)
`ifdef UNPERMUTE_RANGE_CHECK_EN
        ,
        .o_range_err(range_err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    beat_t mq[$];
    int    mcnt = 0;
    bit    mstarted = 0;
    bit    merr = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t ref_a(input vec_t x, input vec_t y, input bit p);
        vec_t r;
        for (int j = 0; j < N; j++) begin
            if (!p) r[j] = x[j];
            else if (j < H) r[j] = x[2*j];
            else r[j] = y[2*(j-H)];
        end
        return r;
    endfunction

    function automatic vec_t ref_b(input vec_t x, input vec_t y, input bit p);
        vec_t r;
        for (int j = 0; j < N; j++) begin
            if (!p) r[j] = y[j];
            else if (j < H) r[j] = x[2*j+1];
            else r[j] = y[2*(j-H)+1];
        end
        return r;
    endfunction

    function automatic bit model_ready();
        return mstarted && (mq.size() < 2) && !flush;
    endfunction

    task automatic model_clear();
        mq.delete();
        mcnt = 0;
        mstarted = 0;
        merr = 0;
    endtask

    task automatic check_all();
        chk("o_valid", 512'(out_valid), 512'(mq.size() > 0));
        chk("o_ready", 512'(in_ready), 512'(model_ready()));
        if (mq.size() > 0) begin
            chk("o_a", out_a, mq[0].a);
            chk("o_b", out_b, mq[0].b);
            chk("o_last", 512'(out_last), 512'(mq[0].last));
        end
`ifdef UNPERMUTE_RANGE_CHECK_EN
        chk("o_range_err", 512'(range_err), 512'(merr));
`endif
    endtask

    // One clock: predict transfers from pre-edge inputs, update model, then compare.
    task automatic step();
        bit    inf, outf;
        beat_t nb;
        inf  = in_valid && model_ready();
        outf = (mq.size() > 0) && out_ready;
        nb.a = ref_a(in_a, in_b, intt && permute);
        nb.b = ref_b(in_a, in_b, intt && permute);
        nb.last = (mcnt == BPP - 1);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) begin
                mq.push_back(nb);
                mcnt = (mcnt + 1) % BPP;
                for (int k = 0; k < N; k++)
                    if (in_a[k] >= 16'd3329 || in_b[k] >= 16'd3329) merr = 1;
            end
        end
        mstarted = 1;
        #1;
        check_all();
    endtask

    // Finish a reset that is already asserted: release after a clock and check reset state.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst o_valid", 512'(out_valid), 512'(0));
        chk("rst o_a", out_a, '0);
        chk("rst o_b", out_b, '0);
        chk("rst o_last", 512'(out_last), 512'(0));
        chk("rst o_ready", 512'(in_ready), 512'(0));
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        release_reset();
    endtask

    function automatic vec_t ramp(input int base);
        vec_t r;
        for (int k = 0; k < N; k++) r[k] = 16'(base + k);
        return r;
    endfunction

    function automatic vec_t fill(input int v);
        vec_t r;
        for (int k = 0; k < N; k++) r[k] = 16'(v);
        return r;
    endfunction

    vec_rec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 1, 3, 16'd6, 16'd7};
        tbl[1] = '{1, 1, 19, 16'h106, 16'h107};
        tbl[2] = '{1, 1, 0, 16'd0, 16'd1};
        tbl[3] = '{1, 1, 15, 16'd30, 16'd31};
        tbl[4] = '{1, 1, 31, 16'h11E, 16'h11F};
        tbl[5] = '{0, 1, 5, 16'd5, 16'h105};
        tbl[6] = '{1, 0, 3, 16'd3, 16'h103};
        tbl[7] = '{0, 0, 19, 16'd19, 16'h113};

        model_clear();
        #1;
        release_reset();

        // Table-driven mapping checks
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            in_a = ramp(0);
            in_b = ramp(16'h100);
            intt = tbl[t].intt;
            permute = tbl[t].perm;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("tbl o_valid", 512'(out_valid), 512'(1));
            chk("tbl o_a lane", 512'(out_a[tbl[t].lane]), 512'(tbl[t].ea));
            chk("tbl o_b lane", 512'(out_b[tbl[t].lane]), 512'(tbl[t].eb));
            step();
        end

        // Passthrough over every lane
        in_a = ramp(0);
        in_b = ramp(16'h100);
        intt = 1'b0;
        permute = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pass o_a", out_a, ramp(0));
        chk("pass o_b", out_b, ramp(16'h100));
        step();

        // Backpressure: beats tagged 1,2,3 with output stalled
        intt = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = fill(1); in_b = fill(1);
        step();
        in_a = fill(2); in_b = fill(2);
        step();
        chk("bp o_ready low", 512'(in_ready), 512'(0));
        in_a = fill(3); in_b = fill(3);
        step();
        step();
        chk("bp hold beat1", 512'(out_a[0]), 512'(1));
        out_ready = 1'b1;
        step();
        chk("bp drain beat2", 512'(out_a[0]), 512'(2));
        step();
        chk("bp drain beat3", 512'(out_a[0]), 512'(3));
        in_valid = 1'b0;
        step();
        chk("bp empty", 512'(out_valid), 512'(0));

        // Polynomial boundary: 9 beats, no stall
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            in_a = fill(n); in_b = fill(n);
            step();
            chk("poly o_last", 512'(out_last), 512'((n == 4) || (n == 8)));
        end
        in_valid = 1'b0;
        step();

        // Flush with two beats buffered, then counter restarts
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        chk("flush o_valid", 512'(out_valid), 512'(0));
        flush = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("flush o_last", 512'(out_last), 512'(n == 4));
        end
        in_valid = 1'b0;
        step();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst o_valid", 512'(out_valid), 512'(0));
        model_clear();
        release_reset();

`ifdef UNPERMUTE_RANGE_CHECK_EN
        // Range check: 3328 passes, 3329 sets a sticky flag that survives flush
        out_ready = 1'b1;
        in_a = fill(3328); in_b = fill(3328);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("range 3328", 512'(range_err), 512'(0));
        in_a = '0; in_b = '0;
        in_b[5] = 16'd3329;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("range 3329", 512'(range_err), 512'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("range sticky", 512'(range_err), 512'(1));
        do_reset();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            intt = $urandom_range(0, 1);
            permute = $urandom_range(0, 1);
            for (int k = 0; k < N; k++) begin
                in_a[k] = 16'($urandom_range(0, 3400));
                in_b[k] = 16'($urandom_range(0, 3400));
            end
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
